aesl_deadlock_param_monitor: RTL and testbench

Parametrised deadlock monitor for one HLS dataflow or pipeline instance in the yolo_conv co-simulation bench. It reduces per-channel AXIS block signals and per-sub-instance block/idle signals to a raw "stuck" condition. The block flag asserts only after that condition persists for a programmable number of cycles, and a sticky report records which sources were blocking and when. It replaces the fixed-width, single-cycle per-index monitors and plugs into the same monitor tree.

---
 rtl/aesl_deadlock_param_monitor.sv | 138 +++++++++++++
 tb/tb_aesl_deadlock_param_monitor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aesl_deadlock_param_monitor.sv
// aesl_deadlock_param_monitor
//
// Deadlock monitor for one HLS dataflow/pipeline instance. Per-channel AXIS
// block signals and per-sub-instance block/idle signals are reduced to a raw
// "stuck" condition. The block flag is raised only once that condition has
// persisted for THRESH consecutive cycles. A capture of the contributing
// sources and a cycle stamp is taken on every entry into BLOCKED.
//
// State table:
//   state     | meaning
//   S_IDLE    | raw condition absent, nothing pending
//   S_SUSPECT | raw present for fewer than THRESH cycles
//   S_BLOCKED | deadlock flagged, capture frozen
//
// Ports:
//   clock            in   clock
//   reset            in   synchronous, active-high reset
//   axis_block_sigs  in   [N_AXIS] per-channel blocked indication
//   inst_idle_sigs   in   [N_INST] per-sub-instance idle (idle never contributes)
//   inst_block_sigs  in   [N_INST] per-sub-instance blocked indication
//   clear            in   synchronous clear of flag and capture
//   block            out  deadlock flag (high in BLOCKED only)
//   report           out  one-cycle pulse on entry to BLOCKED
//   block_src        out  [N_INST+N_AXIS] captured contributors {inst, axis}
//   block_cycle      out  [CNT_W] cycle stamp at BLOCKED entry
module aesl_deadlock_param_monitor #(
  parameter int                N_AXIS    = 4,
  parameter int                N_INST    = 4,
  parameter logic [N_AXIS-1:0] AXIS_MASK = {N_AXIS{1'b1}},
  parameter logic [N_INST-1:0] PAR_MASK  = '0,
  parameter int                THRESH    = 1,
  parameter bit                STICKY    = 1'b1,
  parameter int                CNT_W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_AXIS-1:0]        axis_block_sigs,
  input  logic [N_INST-1:0]        inst_idle_sigs,
  input  logic [N_INST-1:0]        inst_block_sigs,
  input  logic                     clear,
  output logic                     block,
  output logic                     report,
  output logic [N_INST+N_AXIS-1:0] block_src,
  output logic [CNT_W-1:0]         block_cycle
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUSPECT = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  localparam logic [16:0] THRESH_L = 17'(THRESH);

  state_t                     state, state_nx;
  logic [15:0]                persist, persist_nx, persist_inc;
  logic [16:0]                persist_p1;
  logic [CNT_W-1:0]           cycle_cnt;
  logic [N_AXIS-1:0]          axis_hit;
  logic [N_INST-1:0]          single_hit;
  logic                       par_all;
  logic                       raw;
  logic [N_INST+N_AXIS-1:0]   src_now;
  logic                       enter_blk;

  // Raw stuck condition: purely combinational from the inputs.
  always_comb begin
    axis_hit   = axis_block_sigs & AXIS_MASK;
    // Parallel-group members only count as a whole group, never singly.
    single_hit = inst_block_sigs & ~PAR_MASK & ~inst_idle_sigs;
    par_all    = (PAR_MASK != '0) && ((inst_block_sigs & PAR_MASK) == PAR_MASK);
    raw        = (|axis_hit) || (|single_hit) || par_all;
    src_now    = {single_hit | (par_all ? PAR_MASK : '0), axis_hit};
  end

  // 17-bit sum so the compare against THRESH cannot overflow.
  assign persist_p1  = {1'b0, persist} + 17'd1;
  assign persist_inc = (persist == 16'hFFFF) ? persist : persist_p1[15:0];

  always_comb begin
    state_nx   = state;
    persist_nx = raw ? persist_inc : 16'd0;
    case (state)
      S_IDLE: begin
        if (raw) begin
          state_nx = (THRESH_L == 17'd1) ? S_BLOCKED : S_SUSPECT;
        end
      end
      S_SUSPECT: begin
        if (!raw) begin
          state_nx = S_IDLE;
        end else if (persist_p1 == THRESH_L) begin
          state_nx = S_BLOCKED;
        end
      end
      S_BLOCKED: begin
        if (!STICKY && !raw) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // clear wins over raw on the same edge; raw is looked at again next edge.
    if (clear) begin
      state_nx   = S_IDLE;
      persist_nx = 16'd0;
    end
    enter_blk = (state_nx == S_BLOCKED) && (state != S_BLOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      persist     <= 16'd0;
      cycle_cnt   <= '0;
      report      <= 1'b0;
      block_src   <= '0;
      block_cycle <= '0;
    end else begin
      state   <= state_nx;
      persist <= persist_nx;
      report  <= enter_blk;
      if (cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (clear) begin
        block_src   <= '0;
        block_cycle <= '0;
      end else if (enter_blk) begin
        block_src   <= src_now;
        block_cycle <= cycle_cnt;
      end
    end
  end

  assign block = (state == S_BLOCKED);

endmodule

// File: tb/tb_aesl_deadlock_param_monitor.sv
// Directed testbench for aesl_deadlock_param_monitor. Four instances with
// different parameter sets share clock and reset:
//   u_a : THRESH=1, STICKY=1
//   u_b : THRESH=4, STICKY=1, PAR_MASK=0011
//   u_c : THRESH=2, STICKY=0, AXIS_MASK=0111
//   u_d : THRESH=1, CNT_W=4 (stamp saturation)
module tb_aesl_deadlock_param_monitor;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [3:0] a_axis, a_idle, a_iblk; logic a_clear, a_block, a_report;
  logic [7:0] a_src; logic [31:0] a_cycle;
  logic [3:0] b_axis, b_idle, b_iblk; logic b_clear, b_block, b_report;
  logic [7:0] b_src; logic [31:0] b_cycle;
  logic [3:0] c_axis, c_idle, c_iblk; logic c_clear, c_block, c_report;
  logic [7:0] c_src; logic [31:0] c_cycle;
  logic [3:0] d_axis, d_idle, d_iblk; logic d_clear, d_block, d_report;
  logic [7:0] d_src; logic [3:0] d_cycle;

  aesl_deadlock_param_monitor #(.THRESH(1), .STICKY(1'b1)) u_a (
    .clock(clock), .reset(reset), .axis_block_sigs(a_axis),
    .inst_idle_sigs(a_idle), .inst_block_sigs(a_iblk), .clear(a_clear),
    .block(a_block), .report(a_report), .block_src(a_src), .block_cycle(a_cycle));

  aesl_deadlock_param_monitor #(.THRESH(4), .STICKY(1'b1), .PAR_MASK(4'b0011)) u_b (
    .clock(clock), .reset(reset), .axis_block_sigs(b_axis),
    .inst_idle_sigs(b_idle), .inst_block_sigs(b_iblk), .clear(b_clear),
    .block(b_block), .report(b_report), .block_src(b_src), .block_cycle(b_cycle));

  aesl_deadlock_param_monitor #(.THRESH(2), .STICKY(1'b0), .AXIS_MASK(4'b0111)) u_c (
    .clock(clock), .reset(reset), .axis_block_sigs(c_axis),
    .inst_idle_sigs(c_idle), .inst_block_sigs(c_iblk), .clear(c_clear),
    .block(c_block), .report(c_report), .block_src(c_src), .block_cycle(c_cycle));

  aesl_deadlock_param_monitor #(.THRESH(1), .CNT_W(4)) u_d (
    .clock(clock), .reset(reset), .axis_block_sigs(d_axis),
    .inst_idle_sigs(d_idle), .inst_block_sigs(d_iblk), .clear(d_clear),
    .block(d_block), .report(d_report), .block_src(d_src), .block_cycle(d_cycle));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // model of the DUT cycle counter (no saturation needed at 32 bits)
  int cap, cap1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) cyc = 0; else cyc = cyc + 1;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {a_axis, a_idle, a_iblk, a_clear} = '0;
    {b_axis, b_idle, b_iblk, b_clear} = '0;
    {c_axis, c_idle, c_iblk, c_clear} = '0;
    {d_axis, d_idle, d_iblk, d_clear} = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_block",  a_block,  0);
    chk("rst_report", a_report, 0);
    chk("rst_src",    a_src,    0);
    chk("rst_cycle",  a_cycle,  0);

    // THRESH=1: single-cycle raw at cycle 5
    repeat (5) tick();
    a_axis = 4'b0010;
    tick();
    chk("t1_block",  a_block,  1);
    chk("t1_report", a_report, 1);
    chk("t1_src",    a_src,    8'b0000_0010);
    chk("t1_cycle",  a_cycle,  5);
    a_axis = 4'b0000;
    tick();
    chk("t1_report_drop", a_report, 0);
    chk("t1_sticky",      a_block,  1);
    a_axis = 4'b0100;   // new contributor must not alter frozen capture
    tick();
    chk("t1_frozen_src",   a_src,   8'b0000_0010);
    chk("t1_frozen_cycle", a_cycle, 5);
    a_axis = 4'b0000;
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("t1_clr_block", a_block, 0);
    chk("t1_clr_src",   a_src,   0);
    chk("t1_clr_cycle", a_cycle, 0);

    // clear and raw together while BLOCKED
    a_axis = 4'b0001;
    tick();
    chk("t6_block", a_block, 1);
    a_clear = 1'b1;
    tick();
    chk("t6_clr_block",  a_block,  0);
    chk("t6_clr_report", a_report, 0);
    chk("t6_clr_src",    a_src,    0);
    chk("t6_clr_cycle",  a_cycle,  0);
    a_clear = 1'b0;
    cap = cyc;
    tick();
    chk("t6_reblock",  a_block,  1);
    chk("t6_rereport", a_report, 1);
    chk("t6_recycle",  a_cycle,  cap);
    a_axis = 4'b0000; a_clear = 1'b1; tick(); a_clear = 1'b0;

    // THRESH=4: 3-cycle glitches never flag
    for (int r = 0; r < 5; r++) begin
      b_axis = 4'b0001;
      repeat (3) begin
        tick();
        chk("t2_glitch_block",  b_block,  0);
        chk("t2_glitch_report", b_report, 0);
      end
      b_axis = 4'b0000;
      tick();
      chk("t2_gap_block", b_block, 0);
    end
    b_axis = 4'b0001;
    repeat (3) begin tick(); chk("t2_pre_block", b_block, 0); end
    cap = cyc;
    tick();
    chk("t2_block",  b_block,  1);
    chk("t2_report", b_report, 1);
    chk("t2_src",    b_src,    8'b0000_0001);
    chk("t2_cycle",  b_cycle,  cap);
    b_axis = 4'b0000; b_clear = 1'b1; tick(); b_clear = 1'b0;

    // parallel group 0011: one member alone never flags
    b_iblk = 4'b0001;
    repeat (6) begin tick(); chk("t3_partial", b_block, 0); end
    b_iblk = 4'b0011;
    repeat (3) begin tick(); chk("t3_pre", b_block, 0); end
    tick();
    chk("t3_block", b_block, 1);
    chk("t3_src",   b_src,   8'b0011_0000);
    b_iblk = 4'b0000; b_clear = 1'b1; tick(); b_clear = 1'b0;

    // idle instance suppresses its block
    b_iblk = 4'b0100; b_idle = 4'b0100;
    repeat (6) begin tick(); chk("t4_idle", b_block, 0); end
    b_idle = 4'b0000;
    repeat (3) begin tick(); chk("t4_pre", b_block, 0); end
    tick();
    chk("t4_block", b_block, 1);
    chk("t4_src",   b_src,   8'b0100_0000);
    b_iblk = 4'b0000; b_clear = 1'b1; tick(); b_clear = 1'b0;

    // masked axis channel ignored
    c_axis = 4'b1000;
    repeat (3) begin tick(); chk("t5_masked", c_block, 0); end
    c_axis = 4'b0000;
    tick();

    // STICKY=0, THRESH=2: two episodes
    c_axis = 4'b0001;
    tick();
    chk("t5_suspect", c_block, 0);
    cap1 = cyc;
    tick();
    chk("t5_block1",  c_block,  1);
    chk("t5_report1", c_report, 1);
    chk("t5_cycle1",  c_cycle,  cap1);
    repeat (4) begin
      tick();
      chk("t5_hold",   c_block,  1);
      chk("t5_single", c_report, 0);
    end
    c_axis = 4'b0000;
    tick();
    chk("t5_drop", c_block, 0);
    tick();
    c_axis = 4'b0001;
    tick();
    cap = cyc;
    tick();
    chk("t5_block2",  c_block,  1);
    chk("t5_report2", c_report, 1);
    chk("t5_cycle2",  c_cycle,  cap);
    chk("t5_later",   (c_cycle > cap1) ? 1 : 0, 1);
    c_axis = 4'b0000;
    tick();

    // reset while in SUSPECT
    b_axis = 4'b0001;
    tick(); tick();
    chk("t7_suspect", b_block, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_rst_block",  b_block,  0);
    chk("t7_rst_report", b_report, 0);
    chk("t7_rst_cycle",  b_cycle,  0);
    chk("t7_rst_c",      c_cycle,  0);
    repeat (3) begin
      tick();
      chk("t7_restart", b_block,  0);
      chk("t7_norep",   b_report, 0);
    end
    cap = cyc;
    tick();
    chk("t7_block", b_block, 1);
    chk("t7_cycle", b_cycle, cap);
    b_axis = 4'b0000;

    // 4-bit stamp saturates at 15
    repeat (20) tick();
    d_axis = 4'b0001;
    tick();
    chk("t8_block", d_block, 1);
    chk("t8_sat",   d_cycle, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
